carbonio_pio_edge_irq: RTL and testbench
========================================

Name: carbonio_pio_edge_irq

Overview:
- Downstream consumer of the PIO edge-capture FIFO.
- Drains captured input snapshots, derives per-bit rising and falling edges against the last drained snapshot, and accumulates them into sticky W1C status registers.
- Drives a level interrupt with a programmable holdoff (coalescing) delay and keeps a saturating event counter.
- Sits between the PIO block's FIFO read port and the CarbonIO interrupt/register file.

Parameters:
- WIDTH, 32, snapshot width; must equal the PIO width.
- CNT_W, 5, width of edge_count_i; equals $clog2(EDGE_FIFO_DEPTH+1).
- HOLD_W, 16, width of the holdoff length and counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  drain enable
- edge_count_i  in  CNT_W  FIFO occupancy
- edge_data_i  in  WIDTH  FIFO head word; show-ahead, valid whenever edge_count_i != 0
- edge_pop_o  out  1  FIFO pop strobe; head advances on the clock edge where pop is high
- rise_en  in  WIDTH  per-bit rising-edge enable
- fall_en  in  WIDTH  per-bit falling-edge enable
- holdoff_len  in  HOLD_W  cycles that status must stay pending before irq asserts
- clr_we  in  1  W1C strobe
- clr_rise  in  WIDTH  rise_status bits to clear
- clr_fall  in  WIDTH  fall_status bits to clear
- cnt_clr  in  1  clears event_count
- rise_status  out  WIDTH  sticky rising-edge flags
- fall_status  out  WIDTH  sticky falling-edge flags
- last_state  out  WIDTH  last drained snapshot
- event_count  out  16  saturating count of drained words
- irq  out  1  registered interrupt level

Behaviour:
- Reset (async, rst=1): edge_pop_o=0, rise_status=0, fall_status=0, last_state=0, event_count=0, irq=0, holdoff counter=0, FSM=IDLE. The zero last_state matches the PIO stable-state reset value.
- FSM states: IDLE, POP, SETTLE.
  - IDLE: if enable && edge_count_i != 0, go to POP.
  - POP: edge_pop_o=1 for exactly this cycle. On this edge, with new=edge_data_i and d=new^last_state:
    - rise_status |= d & new & rise_en
    - fall_status |= d & ~new & fall_en
    - last_state <= new
    - event_count increments, saturating at 16'hFFFF
    - Then go to SETTLE.
  - SETTLE: one dead cycle so the FIFO count updates; then go to IDLE.
- Throughput: at most one word per 3 cycles. A word's effect on status is visible the cycle after POP.
- edge_pop_o is a Moore output of POP only. It is never asserted when edge_count_i==0 was sampled in IDLE.
- enable deassert: a pop already in POP/SETTLE completes normally. No new pop starts. Status, irq and counters hold.
- last_state updates for every drained word, even when rise_en/fall_en mask all bits.
- W1C: on clr_we, rise_status &= ~clr_rise and fall_status &= ~clr_fall.
  - If a set and a clear hit the same bit in the same cycle, set wins (the bit ends 1).
- cnt_clr: event_count <= 0. If a POP happens in the same cycle, the result is 1.
- Holdoff (pending = |(rise_status|fall_status), using registered values):
  - pending rises 0->1: load hold_cnt <= holdoff_len.
  - While pending && hold_cnt != 0: decrement hold_cnt.
  - irq <= pending && hold_cnt==0, registered.
  - holdoff_len=0 gives irq one cycle after status becomes nonzero.
  - pending falls to 0: irq <= 0 next cycle, hold_cnt <= 0.
  - New edges arriving while pending=1 do not reload hold_cnt.
- holdoff_len changes take effect only at the next 0->1 load.
- Reset mid-pop: everything returns to reset values immediately. The FIFO is reset by the same domain, so there is no stale pop.

Test Plan:
- Push 0x0000_0001 then 0x0000_0000, rise_en=fall_en=all ones, holdoff_len=0 -> two pops, each edge_pop_o 1 cycle wide and 3 cycles apart; rise_status=0x1, fall_status=0x1, last_state=0, event_count=2, irq=1.
- rise_en=0x0000_00F0, fall_en=0; snapshot 0x0000_0FF0 -> rise_status=0x0000_00F0, fall_status=0, last_state=0x0000_0FF0, irq=1.
- holdoff_len=5, single rising edge on bit 3 -> irq rises exactly 6 cycles after rise_status goes nonzero. A second edge during the holdoff does not delay irq.
- W1C clr_rise=0x8 in the same cycle as a POP setting bit 3 -> bit 3 remains 1. A later clr_rise=0x8 alone -> rise_status=0, irq drops the next cycle.
- enable=0 with edge_count_i=4 -> edge_pop_o stays 0 for 20 cycles. Re-enable -> 4 pops, then edge_pop_o stays 0 once count reaches 0.
- Preload event_count near saturation (0xFFFE plus 3 pops) -> holds 0xFFFF. cnt_clr asserted during a POP -> event_count=1.

Source files
------------

// File: rtl/carbonio_pio_edge_irq.sv
// Drains the PIO edge-capture FIFO, accumulates per-bit rise/fall edges into
// sticky W1C status, and drives a coalesced level interrupt plus an event counter.
module carbonio_pio_edge_irq #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 5,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  edge_count_i,
    input  logic [WIDTH-1:0]  edge_data_i,
    output logic              edge_pop_o,
    input  logic [WIDTH-1:0]  rise_en,
    input  logic [WIDTH-1:0]  fall_en,
    input  logic [HOLD_W-1:0] holdoff_len,
    input  logic              clr_we,
    input  logic [WIDTH-1:0]  clr_rise,
    input  logic [WIDTH-1:0]  clr_fall,
    input  logic              cnt_clr,
    output logic [WIDTH-1:0]  rise_status,
    output logic [WIDTH-1:0]  fall_status,
    output logic [WIDTH-1:0]  last_state,
    output logic [15:0]       event_count,
    output logic              irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_SETTLE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_pop;

    logic [WIDTH-1:0]    r_rise;
    logic [WIDTH-1:0]    r_fall;
    logic [WIDTH-1:0]    r_last;
    logic [15:0]         r_event_count;
    logic                r_irq;
    logic                r_pend_q;
    logic [HOLD_W-1:0]   r_hold;

    logic [WIDTH-1:0]    w_diff;
    logic [WIDTH-1:0]    w_set_rise;
    logic [WIDTH-1:0]    w_set_fall;
    logic [WIDTH-1:0]    w_clr_rise;
    logic [WIDTH-1:0]    w_clr_fall;
    logic                w_pending;
    logic [HOLD_W-1:0]   w_hold_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && (edge_count_i != '0)) begin
                    w_state_nxt = S_POP;
                end
            end
            S_POP: begin
                w_pop       = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_diff     = edge_data_i ^ r_last;
    assign w_set_rise = w_pop ? (w_diff &  edge_data_i & rise_en) : '0;
    assign w_set_fall = w_pop ? (w_diff & ~edge_data_i & fall_en) : '0;
    assign w_clr_rise = clr_we ? clr_rise : '0;
    assign w_clr_fall = clr_we ? clr_fall : '0;

    // Clear is applied before the OR so a same-cycle set survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise <= '0;
            r_fall <= '0;
            r_last <= '0;
        end else begin
            r_rise <= (r_rise & ~w_clr_rise) | w_set_rise;
            r_fall <= (r_fall & ~w_clr_fall) | w_set_fall;
            if (w_pop) begin
                r_last <= edge_data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_event_count <= '0;
        end else if (cnt_clr) begin
            r_event_count <= w_pop ? 16'd1 : 16'd0;
        end else if (w_pop && (r_event_count != 16'hFFFF)) begin
            r_event_count <= r_event_count + 16'd1;
        end
    end

    assign w_pending = |(r_rise | r_fall);

    // irq tracks the value being written into the counter, so holdoff_len=N
    // yields irq N+1 cycles after status first goes nonzero.
    always_comb begin
        w_hold_nxt = '0;
        if (!w_pending) begin
            w_hold_nxt = '0;
        end else if (!r_pend_q) begin
            w_hold_nxt = holdoff_len;
        end else if (r_hold != '0) begin
            w_hold_nxt = r_hold - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold   <= '0;
            r_pend_q <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_hold   <= w_hold_nxt;
            r_pend_q <= w_pending;
            r_irq    <= w_pending && (w_hold_nxt == '0);
        end
    end

    assign edge_pop_o  = (r_state == S_POP);
    assign rise_status = r_rise;
    assign fall_status = r_fall;
    assign last_state  = r_last;
    assign event_count = r_event_count;
    assign irq         = r_irq;

endmodule

// File: tb/tb_carbonio_pio_edge_irq.sv
// Directed bench for carbonio_pio_edge_irq with a small show-ahead FIFO model upstream.
module tb_carbonio_pio_edge_irq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [4:0]  edge_count_i;
    logic [31:0] edge_data_i;
    logic        edge_pop_o;
    logic [31:0] rise_en = '0;
    logic [31:0] fall_en = '0;
    logic [15:0] holdoff_len = '0;
    logic        clr_we = 1'b0;
    logic [31:0] clr_rise = '0;
    logic [31:0] clr_fall = '0;
    logic        cnt_clr = 1'b0;
    logic [31:0] rise_status;
    logic [31:0] fall_status;
    logic [31:0] last_state;
    logic [15:0] event_count;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int underflow = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;

    assign edge_count_i = 5'(wr_ptr - rd_ptr);
    assign edge_data_i  = mem[rd_ptr];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (edge_pop_o) begin
            if (edge_count_i == '0) underflow++;
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    carbonio_pio_edge_irq #(.WIDTH(32), .CNT_W(5), .HOLD_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .edge_count_i(edge_count_i), .edge_data_i(edge_data_i), .edge_pop_o(edge_pop_o),
        .rise_en(rise_en), .fall_en(fall_en), .holdoff_len(holdoff_len),
        .clr_we(clr_we), .clr_rise(clr_rise), .clr_fall(clr_fall), .cnt_clr(cnt_clr),
        .rise_status(rise_status), .fall_status(fall_status), .last_state(last_state),
        .event_count(event_count), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pop();
        int n = 0;
        while (!edge_pop_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pop_seen", {31'd0, edge_pop_o}, 32'd1);
    endtask

    task automatic clear_all();
        clr_we = 1'b1; clr_rise = '1; clr_fall = '1;
        tick(1);
        clr_we = 1'b0; clr_rise = '0; clr_fall = '0;
        tick(3);
    endtask

    initial begin
        int p_first, p_second, ts, ti, npop;
        bit pushed2;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // reset state
        tick(2);
        chk("rst_pop", {31'd0, edge_pop_o}, 32'd0);
        chk("rst_rise", rise_status, 32'h0);
        chk("rst_fall", fall_status, 32'h0);
        chk("rst_last", last_state, 32'h0);
        chk("rst_cnt", {16'd0, event_count}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        tick(1);

        // two pops, 3 cycles apart
        rise_en = '1; fall_en = '1; holdoff_len = 16'd0; enable = 1'b1;
        push(32'h1); push(32'h0);
        p_first = -1; p_second = -1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (edge_pop_o) begin
                if (p_first < 0) p_first = k;
                else if (p_second < 0) p_second = k;
            end
        end
        chk("pop_spacing", 32'(p_second - p_first), 32'd3);
        chk("t1_rise", rise_status, 32'h1);
        chk("t1_fall", fall_status, 32'h1);
        chk("t1_last", last_state, 32'h0);
        chk("t1_cnt", {16'd0, event_count}, 32'd2);
        chk("t1_irq", {31'd0, irq}, 32'd1);
        clear_all();
        chk("t1_irq_clr", {31'd0, irq}, 32'd0);

        // masked enables
        rise_en = 32'h0000_00F0; fall_en = '0;
        push(32'h0000_0FF0);
        tick(8);
        chk("t2_rise", rise_status, 32'h0000_00F0);
        chk("t2_fall", fall_status, 32'h0);
        chk("t2_last", last_state, 32'h0000_0FF0);
        chk("t2_irq", {31'd0, irq}, 32'd1);
        clear_all();

        // holdoff = 5, second edge during holdoff
        rise_en = '1; fall_en = '1; holdoff_len = 16'd5;
        push(32'h0000_0FF8);
        ts = -1; ti = -1; pushed2 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (ts < 0 && rise_status != '0) ts = k;
            if (ti < 0 && irq) ti = k;
            if (ts >= 0 && !pushed2 && k == ts + 1) begin
                push(32'h0000_0FFC);
                pushed2 = 1'b1;
            end
        end
        chk("t3_irq_delay", 32'(ti - ts), 32'd6);
        chk("t3_rise", rise_status, 32'h0000_000C);
        holdoff_len = 16'd0;
        clear_all();

        // same-cycle set and clear on bit 3
        push(32'h0000_0FF4);
        tick(6);
        chk("t4_fall", fall_status, 32'h0000_0008);
        clear_all();
        push(32'h0000_0FFC);
        wait_pop();
        clr_we = 1'b1; clr_rise = 32'h8;
        tick(1);
        clr_we = 1'b0; clr_rise = '0;
        chk("t4_set_wins", rise_status, 32'h0000_0008);
        clr_we = 1'b1; clr_rise = 32'h8;
        tick(1);
        clr_we = 1'b0; clr_rise = '0;
        chk("t4_clr", rise_status, 32'h0);
        chk("t4_irq_hold", {31'd0, irq}, 32'd1);
        tick(1);
        chk("t4_irq_drop", {31'd0, irq}, 32'd0);

        // enable gating
        enable = 1'b0;
        push(32'h0000_0FF8); push(32'h0000_0FFC); push(32'h0000_0FF8); push(32'h0000_0FFC);
        npop = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (edge_pop_o) npop++;
        end
        chk("t5_no_pop", 32'(npop), 32'd0);
        chk("t5_cnt_held", {27'd0, edge_count_i}, 32'd4);
        enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            if (edge_pop_o) npop++;
        end
        chk("t5_pops", 32'(npop), 32'd4);
        chk("t5_empty", {27'd0, edge_count_i}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (edge_pop_o) npop++;
        end
        chk("t5_no_extra", 32'(npop), 32'd4);
        chk("t5_last", last_state, 32'h0000_0FFC);
        chk("t5_rise", rise_status, 32'h0000_0004);
        chk("t5_fall", fall_status, 32'h0000_0004);
        chk("t5_evt", {16'd0, event_count}, 32'd11);

        // saturation and cnt_clr during POP
        force dut.r_event_count = 16'hFFFE;
        #1 release dut.r_event_count;
        tick(1);
        chk("t6_preload", {16'd0, event_count}, 32'h0000_FFFE);
        push(32'h0000_0FF8); push(32'h0000_0FFC); push(32'h0000_0FF8);
        tick(15);
        chk("t6_sat", {16'd0, event_count}, 32'h0000_FFFF);
        push(32'h0000_0FFC);
        wait_pop();
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("t6_clr_pop", {16'd0, event_count}, 32'd1);
        tick(3);

        // async reset in the middle of a pop
        push(32'h0000_0001);
        wait_pop();
        #2 rst = 1'b1;
        #1;
        chk("t7_pop", {31'd0, edge_pop_o}, 32'd0);
        chk("t7_last", last_state, 32'h0);
        chk("t7_rise", rise_status, 32'h0);
        chk("t7_cnt", {16'd0, event_count}, 32'd0);
        chk("t7_irq", {31'd0, irq}, 32'd0);
        tick(2);
        chk("t7_fifo_unpopped", {27'd0, edge_count_i}, 32'd1);
        chk("underflow", 32'(underflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
